// File: rtl/sp_track_ctrl_pkg.sv
// Shared types and constants for the sun-tracking sequencer.
// Latency: none (declarations only).
// Backpressure: none.
package sp_track_pkg;

    // FSM states; the encodings are visible on STAT.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'b000,
        ST_SETTLE  = 3'b001,
        ST_SAMPLE  = 3'b010,
        ST_COMPARE = 3'b011,
        ST_MOVE    = 3'b100,
        ST_HOLD    = 3'b101
    } state_t;

    // Direction codes for direction_lr / direction_ud.
    typedef enum logic [1:0] {
        DIR_IDLE = 2'b00,
        DIR_DEC  = 2'b01,
        DIR_INC  = 2'b10
    } dir_t;

    // Active hill-climb axis.
    typedef enum logic {
        AXIS_H = 1'b0,
        AXIS_V = 1'b1
    } axis_t;

    // Bit positions of the buttons in the edge-detector vector.
    localparam int BTN_W     = 5;
    localparam int BTN_L_IDX = 0;
    localparam int BTN_R_IDX = 1;
    localparam int BTN_U_IDX = 2;
    localparam int BTN_D_IDX = 3;
    localparam int BTN_C_IDX = 4;

endpackage

// File: rtl/sp_track_ctrl_if.sv
// ADC sample handshake between the tracker and the ADC front end.
// Latency: wires only.
// Backpressure: the tracker holds adc_req until the ADC returns adc_valid.
interface sp_track_ctrl_if;
    logic [11:0] V_in;
    logic        adc_valid;
    logic        adc_req;

    modport master (output adc_req, input V_in, input adc_valid);
    modport slave  (input adc_req, output V_in, output adc_valid);
endinterface

// File: rtl/sp_track_ctrl_edge_detect.sv
// Registered rising-edge detector for the debounced button levels.
// Latency: one cycle from level rising to rise_o pulse.
// Backpressure: none; every rising edge yields a one-cycle pulse.
module sp_edge_detect
    import sp_track_pkg::*;
#(
    parameter int W = BTN_W
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] lvl_i,
    output logic [W-1:0] rise_o
);
    logic [W-1:0] lvl_q;
    logic [W-1:0] rise_q;

    // Remember last level and register the high-now/low-before pulse.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            lvl_q  <= '0;
            rise_q <= '0;
        end else begin
            lvl_q  <= lvl_i;
            rise_q <= lvl_i & ~lvl_q;
        end
    end

    assign rise_o = rise_q;
endmodule

// File: rtl/sp_track_ctrl.sv
// Panel servo sequencer: manual jog from buttons, or hill-climb on ADC voltage.
// Latency: jog 2 cycles after button edge; auto iteration SETTLE + ADC wait + 2.
// Backpressure: SAMPLE holds adc_req high indefinitely until adc_valid arrives.
module sp_track_ctrl
    import sp_track_pkg::*;
#(
    parameter int POS_MIN       = 50000,
    parameter int POS_MAX       = 250000,
    parameter int POS_CENTER    = 150000,
    parameter int STEP          = 5000,
    parameter int SETTLE_CYCLES = 2000000,
    parameter int HOLD_CYCLES   = 50000000
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             BTN_L,
    input  logic             BTN_R,
    input  logic             BTN_U,
    input  logic             BTN_D,
    input  logic             BTN_C,
    sp_track_ctrl_if.master  adc,
    output logic [11:0]      max_V_in,
    output logic [31:0]      servo_position_H,
    output logic [31:0]      servo_position_V,
    output logic [1:0]       direction_lr,
    output logic [1:0]       direction_ud,
    output logic [2:0]       STAT,
    output logic             auto_active
);
    localparam logic [31:0] P_MIN     = 32'(POS_MIN);
    localparam logic [31:0] P_MAX     = 32'(POS_MAX);
    localparam logic [31:0] P_CENTER  = 32'(POS_CENTER);
    localparam logic [31:0] P_STEP    = 32'(STEP);
    localparam logic [31:0] P_SET_LD  = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] P_HOLD_LD = 32'(HOLD_CYCLES - 1);

    logic [BTN_W-1:0] rise;

    state_t      state_q, state_d;
    logic [31:0] pos_h_q, pos_h_d, pos_v_q, pos_v_d;
    logic [31:0] best_h_q, best_h_d, best_v_q, best_v_d;
    logic [11:0] max_v_q, max_v_d, sample_q, sample_d;
    logic        adc_req_q, adc_req_d, auto_q, auto_d;
    logic [1:0]  dir_lr_q, dir_lr_d, dir_ud_q, dir_ud_d;
    axis_t       axis_q, axis_d;
    logic        scan_inc_q, scan_inc_d, baseline_q, baseline_d;
    logic [1:0]  fail_cnt_q, fail_cnt_d, conv_cnt_q, conv_cnt_d;
    logic [31:0] cnt_q, cnt_d;

    logic        take_fail;
    logic [1:0]  conv_after_fail;
    logic [31:0] best_act, target;
    logic        move_ok;
    logic [31:0] h_dec, h_inc, v_dec, v_inc;

    sp_edge_detect #(.W(BTN_W)) u_edge (
        .clk_i   (CLK),
        .rst_n_i (RST_N),
        .lvl_i   ({BTN_C, BTN_D, BTN_U, BTN_R, BTN_L}),
        .rise_o  (rise)
    );

    // Clamped jog targets, hill-climb target, and the converged count a failure would produce.
    assign h_dec    = (pos_h_q < P_MIN + P_STEP) ? P_MIN : pos_h_q - P_STEP;
    assign h_inc    = (pos_h_q > P_MAX - P_STEP) ? P_MAX : pos_h_q + P_STEP;
    assign v_dec    = (pos_v_q < P_MIN + P_STEP) ? P_MIN : pos_v_q - P_STEP;
    assign v_inc    = (pos_v_q > P_MAX - P_STEP) ? P_MAX : pos_v_q + P_STEP;
    assign best_act = (axis_q == AXIS_V) ? best_v_q : best_h_q;
    assign move_ok  = scan_inc_q ? (best_act <= P_MAX - P_STEP) : (best_act >= P_MIN + P_STEP);
    assign target   = scan_inc_q ? best_act + P_STEP : best_act - P_STEP;
    assign conv_after_fail = (fail_cnt_q == 2'd1) ? conv_cnt_q + 2'd1 : conv_cnt_q;

    // State register and all datapath registers.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            pos_h_q    <= P_CENTER;
            pos_v_q    <= P_CENTER;
            best_h_q   <= P_CENTER;
            best_v_q   <= P_CENTER;
            max_v_q    <= '0;
            sample_q   <= '0;
            adc_req_q  <= 1'b0;
            auto_q     <= 1'b0;
            dir_lr_q   <= DIR_IDLE;
            dir_ud_q   <= DIR_IDLE;
            axis_q     <= AXIS_H;
            scan_inc_q <= 1'b1;
            baseline_q <= 1'b0;
            fail_cnt_q <= '0;
            conv_cnt_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pos_h_q    <= pos_h_d;
            pos_v_q    <= pos_v_d;
            best_h_q   <= best_h_d;
            best_v_q   <= best_v_d;
            max_v_q    <= max_v_d;
            sample_q   <= sample_d;
            adc_req_q  <= adc_req_d;
            auto_q     <= auto_d;
            dir_lr_q   <= dir_lr_d;
            dir_ud_q   <= dir_ud_d;
            axis_q     <= axis_d;
            scan_inc_q <= scan_inc_d;
            baseline_q <= baseline_d;
            fail_cnt_q <= fail_cnt_d;
            conv_cnt_q <= conv_cnt_d;
            cnt_q      <= cnt_d;
        end
    end

    // Next-state logic: manual jog, hill-climb sequencing, and the shared failure path.
    always_comb begin
        state_d    = state_q;
        pos_h_d    = pos_h_q;
        pos_v_d    = pos_v_q;
        best_h_d   = best_h_q;
        best_v_d   = best_v_q;
        max_v_d    = max_v_q;
        sample_d   = sample_q;
        adc_req_d  = adc_req_q;
        auto_d     = auto_q;
        dir_lr_d   = DIR_IDLE;
        dir_ud_d   = DIR_IDLE;
        axis_d     = axis_q;
        scan_inc_d = scan_inc_q;
        baseline_d = baseline_q;
        fail_cnt_d = fail_cnt_q;
        conv_cnt_d = conv_cnt_q;
        cnt_d      = cnt_q;
        take_fail  = 1'b0;

        if (state_q != ST_IDLE && rise[BTN_C_IDX]) begin
            // Leaving auto mode parks the servos where they are.
            auto_d    = 1'b0;
            adc_req_d = 1'b0;
            state_d   = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (rise[BTN_C_IDX]) begin
                        // A fresh scan starts with clean failure bookkeeping.
                        auto_d     = 1'b1;
                        baseline_d = 1'b1;
                        fail_cnt_d = '0;
                        conv_cnt_d = '0;
                        cnt_d      = P_SET_LD;
                        state_d    = ST_SETTLE;
                    end else begin
                        if (rise[BTN_L_IDX] && !rise[BTN_R_IDX]) begin
                            pos_h_d  = h_dec;
                            dir_lr_d = DIR_DEC;
                        end else if (rise[BTN_R_IDX] && !rise[BTN_L_IDX]) begin
                            pos_h_d  = h_inc;
                            dir_lr_d = DIR_INC;
                        end
                        if (rise[BTN_D_IDX] && !rise[BTN_U_IDX]) begin
                            pos_v_d  = v_dec;
                            dir_ud_d = DIR_DEC;
                        end else if (rise[BTN_U_IDX] && !rise[BTN_D_IDX]) begin
                            pos_v_d  = v_inc;
                            dir_ud_d = DIR_INC;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        adc_req_d = 1'b1;
                        state_d   = ST_SAMPLE;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                ST_SAMPLE: begin
                    adc_req_d = 1'b1;
                    if (adc.adc_valid) begin
                        sample_d  = adc.V_in;
                        adc_req_d = 1'b0;
                        state_d   = ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (baseline_q) begin
                        max_v_d    = sample_q;
                        best_h_d   = pos_h_q;
                        best_v_d   = pos_v_q;
                        baseline_d = 1'b0;
                        state_d    = ST_MOVE;
                    end else if (sample_q > max_v_q) begin
                        max_v_d    = sample_q;
                        best_h_d   = pos_h_q;
                        best_v_d   = pos_v_q;
                        fail_cnt_d = '0;
                        conv_cnt_d = '0;
                        state_d    = ST_MOVE;
                    end else begin
                        take_fail = 1'b1;
                    end
                end
                ST_MOVE: begin
                    if (move_ok) begin
                        if (axis_q == AXIS_V) begin
                            pos_v_d  = target;
                            dir_ud_d = scan_inc_q ? DIR_INC : DIR_DEC;
                        end else begin
                            pos_h_d  = target;
                            dir_lr_d = scan_inc_q ? DIR_INC : DIR_DEC;
                        end
                        cnt_d   = P_SET_LD;
                        state_d = ST_SETTLE;
                    end else begin
                        // A step past the travel limits counts as a failed probe.
                        take_fail = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == '0) begin
                        baseline_d = 1'b1;
                        max_v_d    = '0;
                        fail_cnt_d = '0;
                        conv_cnt_d = '0;
                        cnt_d      = P_SET_LD;
                        state_d    = ST_SETTLE;
                    end else begin
                        cnt_d = cnt_q - 32'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (take_fail) begin
                if (axis_q == AXIS_V) pos_v_d = best_v_q;
                else                  pos_h_d = best_h_q;
                scan_inc_d = ~scan_inc_q;
                if (fail_cnt_q == 2'd1) begin
                    fail_cnt_d = '0;
                    axis_d     = (axis_q == AXIS_V) ? AXIS_H : AXIS_V;
                    conv_cnt_d = conv_after_fail;
                end else begin
                    fail_cnt_d = fail_cnt_q + 2'd1;
                end
                if (conv_after_fail == 2'd2) begin
                    // Both axes exhausted: park on the best point found.
                    pos_h_d = best_h_q;
                    pos_v_d = best_v_q;
                    cnt_d   = P_HOLD_LD;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_MOVE;
                end
            end
        end
    end

    assign adc.adc_req       = adc_req_q;
    assign max_V_in          = max_v_q;
    assign servo_position_H  = pos_h_q;
    assign servo_position_V  = pos_v_q;
    assign direction_lr      = dir_lr_q;
    assign direction_ud      = dir_ud_q;
    assign STAT              = state_q;
    assign auto_active       = auto_q;
endmodule
